// File: rtl/flash_cfi_emu.sv
// flash_cfi_emu: AMD/JEDEC command NOR flash emulator backed by an SDRAM image.
// Decodes unlock/command writes and serves autoselect and DQ7/DQ6 status reads.
// Program and erase become byte writes into SDRAM at sdram_offset + byte address.
// Ports: clk, reset (async, active high); slot side addr/din/we/ce in,
//   dout/data_valid/busy out; SDRAM side sdram_ready/sdram_done/sdram_offset in,
//   sdram_req/sdram_addr/sdram_din out.
// Optional: define FLASH_CHIP_ERASE_EN to enable the chip-erase command.
module flash_cfi_emu #(
  parameter int         ADDR_W    = 23,
  parameter int         SECTOR_W  = 16,
  parameter logic [7:0] MANUF_ID  = 8'h20,
  parameter logic [7:0] DEVICE_ID = 8'h7E,
  parameter logic [(2**(ADDR_W-SECTOR_W))-1:0] PROT_MASK = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] addr,
  input  logic [7:0]        din,
  input  logic              we,
  input  logic              ce,
  output logic [7:0]        dout,
  output logic              data_valid,
  output logic              busy,
  input  logic              sdram_ready,
  input  logic              sdram_done,
  output logic              sdram_req,
  output logic [26:0]       sdram_addr,
  output logic [7:0]        sdram_din,
  input  logic [26:0]       sdram_offset
);

  localparam int SN = ADDR_W - SECTOR_W;

  typedef enum logic [1:0] {
    M_READ, M_AUTOSEL, M_PROG, M_ERASE
  } mode_e;

  mode_e             mode_q, mode_d;
  logic [2:0]        idx_q, idx_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              we_q, rd_q;
  logic              tog_q, tog_d;
  logic              dq7_q, dq7_d;
  logic              pend_q, pend_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [7:0]        pdin_q, pdin_d;
  logic [ADDR_W-1:0] ecnt_q, ecnt_d;
  logic              chip_q, chip_d;
  logic              req_q, req_d;
  logic [26:0]       saddr_q, saddr_d;
  logic [7:0]        sdin_q, sdin_d;

  logic              wr_ev, rd;
  logic              ulk_a, ulk_b;
  logic [SN-1:0]     asec, esec;
  logic              e_skip, e_last, pend_w;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        wdata;

  assign wr_ev  = we & ~we_q & ce;
  assign rd     = ce & ~we;
  assign ulk_a  = (addr[11:1] == 11'h555);
  assign ulk_b  = (addr[11:1] == 11'h2AA);
  assign asec   = addr[ADDR_W-1:SECTOR_W];
  assign esec   = ecnt_q[ADDR_W-1:SECTOR_W];
  assign busy   = (mode_q == M_PROG) | (mode_q == M_ERASE);

  // Chip erase walks the whole array; protected sectors are skipped
  // one sector per cycle without SDRAM traffic.
  assign e_skip = chip_q & PROT_MASK[esec];
  assign e_last = chip_q ? (&ecnt_q) : (&ecnt_q[SECTOR_W-1:0]);
  assign pend_w = ((mode_q == M_PROG) & pend_q) |
                  ((mode_q == M_ERASE) & ~e_skip);
  assign waddr  = (mode_q == M_ERASE) ? ecnt_q : paddr_q;
  assign wdata  = (mode_q == M_ERASE) ? 8'hFF : pdin_q;

  assign sdram_req  = req_q;
  assign sdram_addr = saddr_q;
  assign sdram_din  = sdin_q;
  assign data_valid = rd & (mode_q != M_READ);

  always_comb begin
    dout = 8'h00;
    if (rd) begin
      unique case (mode_q)
        M_AUTOSEL: begin
          unique case (addr[2:1])
            2'b00: dout = MANUF_ID;
            2'b01: dout = DEVICE_ID;
            2'b10: dout = {7'd0, PROT_MASK[asec]};
            default: dout = 8'h01;
          endcase
        end
        M_PROG:  dout = {dq7_q, tog_q, 6'd0};
        M_ERASE: dout = {1'b0, tog_q, 6'd0};
        default: dout = 8'hFF;
      endcase
    end
  end

  always_comb begin
    mode_d  = mode_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    tog_d   = tog_q;
    dq7_d   = dq7_q;
    pend_d  = pend_q;
    paddr_d = paddr_q;
    pdin_d  = pdin_q;
    ecnt_d  = ecnt_q;
    chip_d  = chip_q;
    req_d   = req_q;
    saddr_d = saddr_q;
    sdin_d  = sdin_q;

    if (busy & rd & ~rd_q) tog_d = ~tog_q;

    // SDRAM write engine: one request at a time, idle cycle between.
    if (req_q) begin
      if (sdram_done) begin
        req_d = 1'b0;
        if (mode_q == M_PROG) begin
          pend_d = 1'b0;
          mode_d = M_READ;
        end else if (e_last) begin
          mode_d = M_READ;
        end else begin
          ecnt_d = ecnt_q + ADDR_W'(1);
        end
      end
    end else if (pend_w & sdram_ready) begin
      req_d   = 1'b1;
      saddr_d = sdram_offset + 27'(waddr);
      sdin_d  = wdata;
    end else if ((mode_q == M_ERASE) & e_skip) begin
      if (&esec) mode_d = M_READ;
      else ecnt_d = {esec + SN'(1), {SECTOR_W{1'b0}}};
    end

    // Command decode; bus writes are ignored while busy.
    if (wr_ev & ~busy) begin
      if (cnt_q != 3'd0) begin
        // Armed: this write is program data.
        cnt_d = cnt_q - 3'd1;
        dq7_d = ~din[7];
        if (!PROT_MASK[asec]) begin
          mode_d  = M_PROG;
          pend_d  = 1'b1;
          paddr_d = addr;
          pdin_d  = din;
        end else if (cnt_q == 3'd1) begin
          mode_d = M_READ;
        end
      end else if (din == 8'hF0) begin
        mode_d = M_READ;
        idx_d  = 3'd0;
      end else begin
        idx_d = 3'd0;
        unique case (idx_q)
          3'd0: begin
            if (din == 8'hAA && ulk_a) idx_d = 3'd1;
            else if (din == 8'h50) cnt_d = 3'd2;
            else if (din == 8'h56) cnt_d = 3'd4;
          end
          3'd1: if (din == 8'h55 && ulk_b) idx_d = 3'd2;
          3'd2: begin
            if (ulk_a) begin
              if (din == 8'h90) mode_d = M_AUTOSEL;
              else if (din == 8'hA0) cnt_d = 3'd1;
              else if (din == 8'h80) idx_d = 3'd3;
            end
          end
          3'd3: if (din == 8'hAA && ulk_a) idx_d = 3'd4;
          3'd4: if (din == 8'h55 && ulk_b) idx_d = 3'd5;
          3'd5: begin
            if (din == 8'h30) begin
              // A protected sector erase finishes at once.
              if (!PROT_MASK[asec]) begin
                mode_d = M_ERASE;
                chip_d = 1'b0;
                ecnt_d = {asec, {SECTOR_W{1'b0}}};
              end
            end
`ifdef FLASH_CHIP_ERASE_EN
            else if (din == 8'h10 && ulk_a) begin
              mode_d = M_ERASE;
              chip_d = 1'b1;
              ecnt_d = '0;
            end
`endif
          end
          default: idx_d = 3'd0;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q  <= M_READ;
      idx_q   <= 3'd0;
      cnt_q   <= 3'd0;
      we_q    <= 1'b0;
      rd_q    <= 1'b0;
      tog_q   <= 1'b0;
      dq7_q   <= 1'b0;
      pend_q  <= 1'b0;
      paddr_q <= '0;
      pdin_q  <= 8'h00;
      ecnt_q  <= '0;
      chip_q  <= 1'b0;
      req_q   <= 1'b0;
      saddr_q <= 27'd0;
      sdin_q  <= 8'h00;
    end else begin
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      we_q    <= we;
      rd_q    <= rd;
      tog_q   <= tog_d;
      dq7_q   <= dq7_d;
      pend_q  <= pend_d;
      paddr_q <= paddr_d;
      pdin_q  <= pdin_d;
      ecnt_q  <= ecnt_d;
      chip_q  <= chip_d;
      req_q   <= req_d;
      saddr_q <= saddr_d;
      sdin_q  <= sdin_d;
    end
  end

endmodule

// File: tb/tb_flash_cfi_emu.sv
// tb_flash_cfi_emu: self-checking bench for flash_cfi_emu with a small
// geometry (13-bit address, 512-byte sectors, sector 2 protected).
module tb_flash_cfi_emu;

  localparam int AW = 13;
  localparam int SW = 9;
  localparam int NS = 1 << (AW - SW);
  localparam logic [15:0] PM = 16'h0004;

  logic          clk, reset;
  logic [AW-1:0] addr;
  logic [7:0]    din, dout, sdram_din;
  logic          we, ce, data_valid, busy;
  logic          sdram_ready, sdram_done, sdram_req;
  logic [26:0]   sdram_addr, sdram_offset;

  int total, bad, proto_err, done_dly, tog_cnt;
  bit rdy_rand;
  logic [26:0] wq_a[$];
  logic [7:0]  wq_d[$];

  flash_cfi_emu #(
    .ADDR_W(AW), .SECTOR_W(SW),
    .MANUF_ID(8'h20), .DEVICE_ID(8'h7E),
    .PROT_MASK(PM)
  ) dut (
    .clk(clk), .reset(reset), .addr(addr), .din(din),
    .we(we), .ce(ce), .dout(dout), .data_valid(data_valid),
    .busy(busy), .sdram_ready(sdram_ready),
    .sdram_done(sdram_done), .sdram_req(sdram_req),
    .sdram_addr(sdram_addr), .sdram_din(sdram_din),
    .sdram_offset(sdram_offset)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // SDRAM side: records each request, checks stability and handshake.
  initial begin : resp
    logic rp, rdp;
    logic [26:0] ha;
    logic [7:0] hd;
    int wc;
    rp = 0; rdp = 0; ha = '0; hd = '0; wc = 0;
    sdram_done = 0; sdram_ready = 0;
    forever begin
      @(negedge clk);
      if (sdram_req === 1'b1) begin
        if (!rp) begin
          wq_a.push_back(sdram_addr);
          wq_d.push_back(sdram_din);
          ha = sdram_addr; hd = sdram_din; wc = 0;
          if (!rdp) proto_err++;
        end else if (sdram_addr !== ha || sdram_din !== hd
                     || sdram_done) begin
          proto_err++;
        end
        if (!sdram_done) begin
          if (wc >= done_dly) sdram_done = 1;
          else wc++;
        end
      end else begin
        sdram_done = 0;
      end
      rp = (sdram_req === 1'b1);
      sdram_ready = rdy_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
      rdp = sdram_ready;
    end
  end

  function automatic logic [26:0] sa(input logic [26:0] off, input int a);
    longint s;
    s = (longint'(off) + longint'(a)) % (longint'(1) << 27);
    return s[26:0];
  endfunction

  task automatic bw(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    addr = a; din = d; ce = 1; we = 1;
    @(negedge clk);
    ce = 0; we = 0;
  endtask

  task automatic br(input logic [AW-1:0] a,
                    output logic [7:0] d, output logic v);
    @(negedge clk);
    addr = a; ce = 1; we = 0;
    @(negedge clk);
    d = dout; v = data_valid; ce = 0;
  endtask

  task automatic wait_idle(input int lim, output bit ok);
    ok = 0;
    for (int i = 0; i < lim; i++) begin
      if (busy === 1'b0) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic unlock(input logic [7:0] c);
    bw(13'hAAA, 8'hAA);
    bw(13'h554, 8'h55);
    bw(13'hAAA, c);
  endtask

  task automatic erase_cmd(input logic [AW-1:0] a, input logic [7:0] c);
    unlock(8'h80);
    bw(13'hAAA, 8'hAA);
    bw(13'h554, 8'h55);
    bw(a, c);
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    total++;
    if ({dout, data_valid, busy, sdram_req} !== 11'd0) begin
      bad++;
      $display("FAIL reset_outs got=%h/%b/%b/%b exp=0",
               dout, data_valid, busy, sdram_req);
    end
    total++;
    if ({sdram_addr, sdram_din} !== 35'd0) begin
      bad++;
      $display("FAIL reset_sdram got=%h/%h exp=0", sdram_addr, sdram_din);
    end
    reset = 0;
    @(negedge clk); @(negedge clk);
    total++;
    if (busy !== 1'b0 || sdram_req !== 1'b0) begin
      bad++;
      $display("FAIL reset_release got=%b/%b exp=0/0", busy, sdram_req);
    end
  endtask

  task automatic test_autosel();
    logic [7:0] d, e;
    logic v;
    logic [AW-1:0] a;
    int sec;
    unlock(8'h90);
    for (int i = 0; i < 12; i++) begin
      if (i < 4) a = AW'(2 * i);
      else if (i == 4) a = 13'h404;
      else a = AW'($urandom_range(0, (1 << AW) - 1));
      sec = int'(a) / (1 << SW);
      case ((int'(a) / 2) % 4)
        0: e = 8'h20;
        1: e = 8'h7E;
        2: e = {7'd0, PM[sec]};
        default: e = 8'h01;
      endcase
      br(a, d, v);
      total++;
      if (d !== e || v !== 1'b1) begin
        bad++;
        $display("FAIL autosel a=%h got=%h/%b exp=%h/1", a, d, v, e);
      end
    end
    bw(13'h123, 8'hF0);
    br(13'h0, d, v);
    total++;
    if (d !== 8'hFF || v !== 1'b0) begin
      bad++;
      $display("FAIL autosel_exit got=%h/%b exp=ff/0", d, v);
    end
  endtask

  task automatic test_program();
    logic [7:0] d;
    logic v;
    bit ok, seen;
    int pe;
    pe = proto_err;
    sdram_offset = 27'h7FFFFF0;
    rdy_rand = 0; done_dly = 30;
    wq_a.delete(); wq_d.delete();
    unlock(8'hA0);
    bw(13'h1234, 8'h3C);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      if (sdram_req === 1'b1) begin seen = 1; break; end
      @(negedge clk);
    end
    total++;
    if (!seen || sdram_addr !== sa(27'h7FFFFF0, 'h1234)
        || sdram_din !== 8'h3C) begin
      bad++;
      $display("FAIL prog_req got=%b/%h/%h exp=1/%h/3c", seen,
               sdram_addr, sdram_din, sa(27'h7FFFFF0, 'h1234));
    end
    for (int i = 0; i < 3; i++) begin
      br(13'h0, d, v);
      tog_cnt++;
      total++;
      if (d !== {1'b1, 1'(tog_cnt % 2), 6'd0} || v !== 1'b1
          || busy !== 1'b1) begin
        bad++;
        $display("FAIL prog_status rd%0d got=%h/%b exp=%h/1", i, d, v,
                 {1'b1, 1'(tog_cnt % 2), 6'd0});
      end
    end
    wait_idle(200, ok);
    total++;
    if (!ok || wq_a.size() != 1 || proto_err != pe) begin
      bad++;
      $display("FAIL prog_done got=%b/%0d/%0d exp=1/1/%0d", ok,
               wq_a.size(), proto_err, pe);
    end
  endtask

  task automatic test_multi();
    logic [26:0] off;
    logic [26:0] ea[$];
    logic [7:0]  ed[$];
    logic [AW-1:0] a;
    logic [7:0] d;
    logic v;
    int n, nb;
    bit ok;
    off = 27'($urandom);
    sdram_offset = off;
    rdy_rand = 1;
    wq_a.delete(); wq_d.delete();
    for (int rep = 0; rep < 3; rep++) begin
      n = (rep == 1) ? 2 : 4;
      bw(AW'($urandom), (n == 2) ? 8'h50 : 8'h56);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 3) == 0)
          a = AW'(32'h400 + $urandom_range(0, 511));
        else a = AW'($urandom);
        d = 8'($urandom);
        done_dly = $urandom_range(0, 3);
        if (!PM[int'(a) / (1 << SW)]) begin
          ea.push_back(sa(off, int'(a)));
          ed.push_back(d);
        end
        bw(a, d);
        wait_idle(200, ok);
        total++;
        if (!ok) begin
          bad++;
          $display("FAIL multi_idle rep=%0d k=%0d busy=%b exp=0",
                   rep, k, busy);
        end
      end
    end
    nb = 0;
    for (int i = 0; i < ea.size() && i < wq_a.size(); i++)
      if (wq_a[i] !== ea[i] || wq_d[i] !== ed[i]) nb++;
    total++;
    if (wq_a.size() != ea.size() || nb != 0) begin
      bad++;
      $display("FAIL multi_writes got=%0d(bad %0d) exp=%0d",
               wq_a.size(), nb, ea.size());
    end
    bw(13'h0777, 8'h12);
    repeat (10) @(negedge clk);
    br(13'h0, d, v);
    total++;
    if (wq_a.size() != ea.size() || busy !== 1'b0
        || d !== 8'hFF || v !== 1'b0) begin
      bad++;
      $display("FAIL multi_extra got=%0d/%b/%h/%b exp=%0d/0/ff/0",
               wq_a.size(), busy, d, v, ea.size());
    end
  endtask

  task automatic test_sector_erase();
    logic [26:0] off;
    int nb, pe;
    bit ok;
    off = 27'($urandom);
    sdram_offset = off;
    rdy_rand = 1; done_dly = 3;
    pe = proto_err;
    wq_a.delete(); wq_d.delete();
    erase_cmd(AW'(32'h600 + $urandom_range(0, 511)), 8'h30);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL serase_busy got=%b exp=1", busy);
    end
    bw(13'hAAA, 8'hF0);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL serase_f0_ignored got=%b exp=1", busy);
    end
    wait_idle(30000, ok);
    nb = 0;
    for (int i = 0; i < wq_a.size() && i < 512; i++)
      if (wq_a[i] !== sa(off, 'h600 + i) || wq_d[i] !== 8'hFF) nb++;
    total++;
    if (!ok || wq_a.size() != 512 || nb != 0 || proto_err != pe) begin
      bad++;
      $display("FAIL serase got=%b/%0d/%0d/%0d exp=1/512/0/%0d",
               ok, wq_a.size(), nb, proto_err, pe);
    end
  endtask

  task automatic test_protected_erase();
    int nbusy;
    wq_a.delete(); wq_d.delete();
    rdy_rand = 0; done_dly = 0;
    erase_cmd(13'h410, 8'h30);
    nbusy = (busy === 1'b1) ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (busy === 1'b1) nbusy++;
    end
    total++;
    if (!(nbusy <= 1) || wq_a.size() != 0) begin
      bad++;
      $display("FAIL prot_erase busy=%0d wr=%0d exp<=1/0",
               nbusy, wq_a.size());
    end
  endtask

  task automatic test_chip_erase();
    logic [26:0] off;
    int nb, ne;
    bit ok;
    off = 27'($urandom);
    sdram_offset = off;
    rdy_rand = 0; done_dly = 0;
    wq_a.delete(); wq_d.delete();
    erase_cmd(13'hAAA, 8'h10);
`ifdef FLASH_CHIP_ERASE_EN
    wait_idle(40000, ok);
    nb = 0; ne = 0;
    for (int s = 0; s < NS; s++) begin
      if (!PM[s]) begin
        for (int j = 0; j < (1 << SW); j++) begin
          if (ne >= wq_a.size() || wq_a[ne] !== sa(off, s * (1 << SW) + j)
              || wq_d[ne] !== 8'hFF) nb++;
          ne++;
        end
      end
    end
    total++;
    if (!ok || wq_a.size() != ne || nb != 0) begin
      bad++;
      $display("FAIL chip_erase got=%b/%0d/%0d exp=1/%0d/0",
               ok, wq_a.size(), nb, ne);
    end
`else
    ok = (busy === 1'b0);
    bw(13'h600, 8'h30);
    nb = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) nb++;
      @(negedge clk);
    end
    ne = 0;
    total++;
    if (!ok || nb != 0 || wq_a.size() != ne) begin
      bad++;
      $display("FAIL chip_erase_off got=%b/%0d/%0d exp=1/0/0",
               ok, nb, wq_a.size());
    end
`endif
  endtask

  task automatic test_bad_unlock();
    logic [7:0] d;
    logic v;
    bw(13'hAAA, 8'hAA);
    bw(13'h100, 8'h55);
    bw(13'hAAA, 8'h90);
    br(13'h0, d, v);
    total++;
    if (d !== 8'hFF || v !== 1'b0) begin
      bad++;
      $display("FAIL bad_unlock got=%h/%b exp=ff/0", d, v);
    end
    unlock(8'h90);
    br(13'h2, d, v);
    total++;
    if (d !== 8'h7E || v !== 1'b1) begin
      bad++;
      $display("FAIL relock got=%h/%b exp=7e/1", d, v);
    end
    bw(13'h0, 8'hF0);
  endtask

  task automatic test_reset_abort();
    logic [7:0] d;
    logic v;
    rdy_rand = 0; done_dly = 3;
    sdram_offset = 27'($urandom);
    erase_cmd(13'hA00, 8'h30);
    repeat (40) @(negedge clk);
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL abort_pre busy=%b exp=1", busy);
    end
    @(negedge clk);
    #1 reset = 1;
    #1;
    total++;
    if (sdram_req !== 1'b0 || busy !== 1'b0 || sdram_addr !== 27'd0) begin
      bad++;
      $display("FAIL abort got=%b/%b/%h exp=0/0/0",
               sdram_req, busy, sdram_addr);
    end
    @(negedge clk);
    reset = 0;
    tog_cnt = 0;
    br(13'h0, d, v);
    total++;
    if (d !== 8'hFF || v !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_read got=%h/%b/%b exp=ff/0/0", d, v, busy);
    end
  endtask

  initial begin
    total = 0; bad = 0; proto_err = 0; done_dly = 0; tog_cnt = 0;
    rdy_rand = 0;
    reset = 1; addr = '0; din = 8'h00; we = 0; ce = 0;
    sdram_offset = 27'd0;
    test_reset();
    test_autosel();
    test_program();
    test_multi();
    test_sector_erase();
    test_protected_erase();
    test_chip_erase();
    test_bad_unlock();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/flash_cfi_emu.md
Name: flash_cfi_emu

Overview:
- Parametrised AMD/JEDEC-command NOR flash emulator for cartridge slots. It supersedes the fixed 23-bit, ID-hardcoded flash model.
- Decodes the unlock/command write sequences from the slot bus and serves autoselect and status reads.
- Performs program, sector erase and chip erase by issuing byte writes into the SDRAM-backed image at `sdram_offset`.
- Adds configurable geometry, IDs and a per-sector write-protect mask. Busy-status polling (DQ7 data#, DQ6 toggle) and reset-abort are also new.

Parameters:
- ADDR_W, 23, slot byte-address width.
- SECTOR_W, 16, log2 of sector size in bytes. Sector count NSEC = 2^(ADDR_W-SECTOR_W).
- MANUF_ID, 8'h20, autoselect manufacturer code.
- DEVICE_ID, 8'h7E, autoselect device code.
- PROT_MASK, {NSEC{1'b0}}, bit n = 1 makes sector n read-only.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- addr  in  ADDR_W  slot byte address
- din  in  8  write data
- we  in  1  write strobe; rising edge while ce=1 = one bus write
- ce  in  1  chip select
- dout  out  8  autoselect/status data
- data_valid  out  1  dout overrides SDRAM read data
- busy  out  1  program/erase in progress
- sdram_ready  in  1  SDRAM can accept request
- sdram_done  in  1  request completed
- sdram_req  out  1  write request
- sdram_addr  out  27  SDRAM byte address
- sdram_din  out  8  SDRAM write data
- sdram_offset  in  27  image base in SDRAM

Behaviour:
- Reset: all outputs 0; mode=READ; cycle index=0; toggle bit=0. An asserted reset aborts any erase/program in flight and drops sdram_req immediately.
- Bus write event: we & ~we_d & ce. Unlock address check uses addr[11:1]: 11'h555 for cycles 0,2,3,5; 11'h2AA for cycles 1,4.
- A mismatched address or data clears the index to 0. The exception is F0 at any address, which always returns mode to READ.
- Decoded sequences (mode READ or AUTOSEL only):
  - AA,55,90: mode AUTOSEL.
  - AA,55,A0: arm program for 1 byte.
  - 50 at cycle 0: arm 2 bytes.
  - 56 at cycle 0: arm 4 bytes.
  - AA,55,80,AA,55,30 at any address: sector erase of addr[ADDR_W-1:SECTOR_W].
  - AA,55,80,AA,55,10 at 555: chip erase.
- Armed program: each following bus write decrements the remaining count and becomes one SDRAM write of din to sdram_offset+addr. Mode is PROG_BUSY until done is received; then the block re-arms if the count is >0, else returns to READ.
- A program to a protected sector is dropped (count still decrements).
- Erase: mode ERASE_BUSY writes 8'hFF to every byte of the target sector(s) ascending from offset 0. A chip erase skips protected sectors. A sector erase of a protected sector completes in 1 cycle with no SDRAM traffic.
- SDRAM handshake:
  - sdram_req rises only when a write is pending and sdram_ready=1.
  - addr/din stay stable while req=1.
  - req falls the cycle after sdram_done is sampled high.
  - The next request is no earlier than the following cycle, so at most 1 outstanding.
- busy = mode ∈ {PROG_BUSY, ERASE_BUSY}. Bus writes during busy are ignored, F0 included.
- Reads (ce & ~we):
  - AUTOSEL, selected by addr[2:1]: 00→MANUF_ID, 01→DEVICE_ID, 10→{7'd0,PROT_MASK[sector]}, 11→8'h01.
  - Busy: dout={DQ7,DQ6,6'd0}. DQ7 = ~last programmed din[7] (program) or 0 (erase). DQ6 toggles on each read rising edge of ce&~we.
  - READ: data_valid=0, dout=8'hFF.
- data_valid = ce & ~we & (mode≠READ).
- Erase counter width is SECTOR_W for sector erase and ADDR_W for chip erase. sdram_addr = sdram_offset + 27'(byte address) and wraps modulo 2^27.

Optional Feature:
- FLASH_CHIP_ERASE_EN defined: the 10 terminator performs chip erase.
- Undefined: cycle 5 with 10 is a mismatch → index 0, mode unchanged, no SDRAM traffic. Sector erase is unaffected.

Test Plan:
- AA@AAA, 55@554, 90@AAA, then read addr 0/2/4/6 → dout 20,7E,00,01 with data_valid=1. F0 → data_valid=0.
- AA,55,A0, then write 3C@0x1234 with sdram_ready=1 → sdram_req=1, sdram_addr=offset+0x1234, din=3C. During busy, read → DQ7=1 and DQ6 alternates on successive reads.
- 56, then four writes → exactly four SDRAM writes. A fifth write produces no request and mode=READ.
- Sector erase at addr 0x30000, SECTOR_W=16 → 65536 writes of FF covering offset+0x30000..0x3FFFF. busy then falls; with sdram_done delayed 3 cycles, req is held stable throughout.
- PROT_MASK bit 2 set: erase at 0x20000 → no sdram_req, busy ≤1 cycle. Chip erase (macro on) skips 0x20000..0x2FFFF.
- Wrong address in cycle 1 (55@0x100) → index reset. Reset asserted mid-erase → sdram_req=0, busy=0 in same cycle, mode=READ.
